zilla_branch_redirect_ctrl: RTL and testbench

Sequencing controller for the decode-stage branch resolver. It stalls a branch/JAL/JALR in decode when an operand is produced by a load still in execute. It latches the resolved target and drives a valid/ready redirect handshake to fetch. It then flushes IF/ID for a programmable number of cycles. It sits between decode, the branch condition/target logic and the fetch unit.

---
 rtl/zilla_branch_pkg.sv | 17 +
 rtl/zilla_sat_counter.sv | 18 +
 rtl/zilla_branch_redirect_ctrl.sv | 124 ++++++++++++
 tb/tb_zilla_branch_redirect_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zilla_branch_pkg.sv
// zilla_branch_pkg: shared FSM encoding and RV control-flow opcodes for the branch redirect controller
package zilla_branch_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HAZ_STALL = 2'd1,
        REDIRECT  = 2'd2,
        FLUSH     = 2'd3
    } br_state_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam int STAT_WIDTH = 32;

endpackage

// File: rtl/zilla_sat_counter.sv
// zilla_sat_counter: 32-bit event counter that sticks at all-ones, with sync clear
module zilla_sat_counter
    import zilla_branch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [STAT_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/zilla_branch_redirect_ctrl.sv
// zilla_branch_redirect_ctrl: load-use stall, redirect handshake and IF/ID flush sequencing for decode branches.
// Statistics counters are built only when ZILLA_BRANCH_STATS_EN is defined.
module zilla_branch_redirect_ctrl
    import zilla_branch_pkg::*;
#(
    parameter int PC_WIDTH       = 20,
    parameter int GPR_ADDR_WIDTH = 5,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic                      bctl_clk,
    input  logic                      bctl_rst,
    input  logic                      wdt_reset_i,
    input  logic                      stall_en_i,
    input  logic                      dec_valid_i,
    input  logic                      dec_is_ctrl_i,
    input  logic                      dec_uses_rs2_i,
    input  logic [GPR_ADDR_WIDTH-1:0] dec_rs1_i,
    input  logic [GPR_ADDR_WIDTH-1:0] dec_rs2_i,
    input  logic                      ex_load_i,
    input  logic [GPR_ADDR_WIDTH-1:0] ex_rd_i,
    input  logic                      br_taken_i,
    input  logic [PC_WIDTH-1:0]       br_target_i,
    input  logic                      fetch_ready_i,
    output logic                      pipe_stall_o,
    output logic                      bubble_id_ex_o,
    output logic                      redirect_valid_o,
    output logic [PC_WIDTH-1:0]       redirect_pc_o,
    output logic                      flush_if_id_o,
    output logic                      busy_o,
    output logic [STAT_WIDTH-1:0]     stat_taken_o,
    output logic [STAT_WIDTH-1:0]     stat_ctrl_o
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES == 0 ? 0 : FLUSH_CYCLES - 1);

    br_state_e           state, state_d;
    logic [2:0]          cnt, cnt_d;
    logic [PC_WIDTH-1:0] redirect_pc_q, pc_d;
    logic                clear, dec_ctrl, hazard;

    assign clear    = !bctl_rst || wdt_reset_i;
    assign dec_ctrl = dec_valid_i && dec_is_ctrl_i;
    assign hazard   = dec_ctrl && ex_load_i && ex_rd_i != '0 &&
                      (ex_rd_i == dec_rs1_i || (dec_uses_rs2_i && ex_rd_i == dec_rs2_i));

    always_ff @(posedge bctl_clk) begin
        if (clear) begin
            state         <= IDLE;
            cnt           <= '0;
            redirect_pc_q <= '0;
        end else if (!stall_en_i) begin
            state         <= state_d;
            cnt           <= cnt_d;
            redirect_pc_q <= pc_d;
        end
    end

    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        pc_d           = redirect_pc_q;
        pipe_stall_o   = 1'b0;
        bubble_id_ex_o = 1'b0;
        case (state)
            IDLE: begin
                if (hazard) begin
                    pipe_stall_o   = 1'b1;
                    bubble_id_ex_o = 1'b1;
                    state_d        = HAZ_STALL;
                end else if (dec_ctrl && br_taken_i) begin
                    pc_d    = {br_target_i[PC_WIDTH-1:1], 1'b0};
                    state_d = REDIRECT;
                end
            end
            // Loaded value is forwarded from MEM now, so the branch resolves this cycle.
            HAZ_STALL: begin
                pc_d    = br_taken_i ? {br_target_i[PC_WIDTH-1:1], 1'b0} : redirect_pc_q;
                state_d = br_taken_i ? REDIRECT : IDLE;
            end
            REDIRECT: begin
                pipe_stall_o = 1'b1;
                if (fetch_ready_i) begin
                    state_d = FLUSH_CYCLES == 0 ? IDLE : FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                state_d = cnt == '0 ? IDLE : FLUSH;
                cnt_d   = cnt == '0 ? cnt : cnt - 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign redirect_valid_o = state == REDIRECT;
    assign flush_if_id_o    = state == REDIRECT || state == FLUSH;
    assign busy_o           = state != IDLE;
    assign redirect_pc_o    = redirect_pc_q;

`ifdef ZILLA_BRANCH_STATS_EN
    logic ctrl_inc, taken_inc;

    assign ctrl_inc  = !stall_en_i && (state == HAZ_STALL || (state == IDLE && dec_ctrl && !hazard));
    assign taken_inc = !stall_en_i && state == REDIRECT && fetch_ready_i;

    zilla_sat_counter u_stat_ctrl (
        .clk   (bctl_clk),
        .rst   (clear),
        .inc   (ctrl_inc),
        .count (stat_ctrl_o)
    );

    zilla_sat_counter u_stat_taken (
        .clk   (bctl_clk),
        .rst   (clear),
        .inc   (taken_inc),
        .count (stat_taken_o)
    );
`else
    assign stat_ctrl_o  = '0;
    assign stat_taken_o = '0;
`endif

endmodule

// File: tb/tb_zilla_branch_redirect_ctrl.sv
// tb_zilla_branch_redirect_ctrl: scenario tasks with a queue of expected redirect targets.
module tb_zilla_branch_redirect_ctrl;

    localparam int PW = 20;
    localparam int AW = 5;
`ifdef ZILLA_BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          bctl_clk = 1'b0;
    logic          bctl_rst = 1'b0;
    logic          wdt_reset_i = 1'b0;
    logic          stall_en_i = 1'b0;
    logic          dec_valid_i, dec_is_ctrl_i, dec_uses_rs2_i;
    logic [AW-1:0] dec_rs1_i, dec_rs2_i, ex_rd_i;
    logic          ex_load_i, br_taken_i;
    logic [PW-1:0] br_target_i;
    logic          fetch_ready_i = 1'b1;
    logic          pipe_stall_o, bubble_id_ex_o, redirect_valid_o, flush_if_id_o, busy_o;
    logic [PW-1:0] redirect_pc_o;
    logic [31:0]   stat_taken_o, stat_ctrl_o;

    int            checks = 0;
    int            errors = 0;
    int            exp_ctrl = 0;
    int            exp_taken = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_pc;

    zilla_branch_redirect_ctrl #(.PC_WIDTH(PW), .GPR_ADDR_WIDTH(AW), .FLUSH_CYCLES(2)) dut (
        .bctl_clk         (bctl_clk),
        .bctl_rst         (bctl_rst),
        .wdt_reset_i      (wdt_reset_i),
        .stall_en_i       (stall_en_i),
        .dec_valid_i      (dec_valid_i),
        .dec_is_ctrl_i    (dec_is_ctrl_i),
        .dec_uses_rs2_i   (dec_uses_rs2_i),
        .dec_rs1_i        (dec_rs1_i),
        .dec_rs2_i        (dec_rs2_i),
        .ex_load_i        (ex_load_i),
        .ex_rd_i          (ex_rd_i),
        .br_taken_i       (br_taken_i),
        .br_target_i      (br_target_i),
        .fetch_ready_i    (fetch_ready_i),
        .pipe_stall_o     (pipe_stall_o),
        .bubble_id_ex_o   (bubble_id_ex_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .flush_if_id_o    (flush_if_id_o),
        .busy_o           (busy_o),
        .stat_taken_o     (stat_taken_o),
        .stat_ctrl_o      (stat_ctrl_o)
    );

    always #5 bctl_clk = ~bctl_clk;

    // Decode must be empty while a redirect or flush is in progress.
    always @(negedge bctl_clk)
        if (bctl_rst && (redirect_valid_o || flush_if_id_o))
            assert (!(dec_valid_i && dec_is_ctrl_i)) else $error("control instruction in decode while busy");

    task automatic tick;
        @(posedge bctl_clk);
        #1;
    endtask

    task automatic clear_dec;
        dec_valid_i = 0; dec_is_ctrl_i = 0; dec_uses_rs2_i = 0;
        dec_rs1_i = 0; dec_rs2_i = 0; ex_load_i = 0; ex_rd_i = 0;
        br_taken_i = 0; br_target_i = 0;
    endtask

    task automatic drive_branch(input logic [PW-1:0] tgt, input logic uses_rs2);
        dec_valid_i = 1; dec_is_ctrl_i = 1; dec_uses_rs2_i = uses_rs2;
        br_taken_i = 1; br_target_i = tgt;
        exp_q.push_back({tgt[PW-1:1], 1'b0});
        exp_ctrl++;
    endtask

    task automatic test_reset;
        clear_dec();
        bctl_rst = 0;
        tick(); tick();
        bctl_rst = 1;
        #1;
        checks++;
        if ({pipe_stall_o, bubble_id_ex_o, redirect_valid_o, flush_if_id_o, busy_o} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {pipe_stall_o, bubble_id_ex_o, redirect_valid_o, flush_if_id_o, busy_o});
        end
        checks++;
        if (redirect_pc_o !== '0 || stat_ctrl_o !== 0 || stat_taken_o !== 0) begin
            errors++; $display("FAIL reset_regs got pc=%h ctrl=%0d taken=%0d want 0", redirect_pc_o, stat_ctrl_o, stat_taken_o);
        end
    endtask

    task automatic test_taken_no_hazard;
        fetch_ready_i = 1;
        drive_branch(20'h00104, 1'b1);
        dec_rs1_i = 3; dec_rs2_i = 4;
        #1;
        checks++;
        if (pipe_stall_o !== 1'b0) begin errors++; $display("FAIL beq_nostall got %b want 0", pipe_stall_o); end
        tick();
        clear_dec();
        #1;
        checks++;
        if ({redirect_valid_o, flush_if_id_o, pipe_stall_o} !== 3'b111) begin
            errors++; $display("FAIL beq_redirect got %b want 111", {redirect_valid_o, flush_if_id_o, pipe_stall_o});
        end
        checks++;
        exp_pc = exp_q.pop_front();
        if (redirect_pc_o !== exp_pc) begin errors++; $display("FAIL beq_pc got %h want %h", redirect_pc_o, exp_pc); end
        exp_taken++;
        tick();
        checks++;
        if ({redirect_valid_o, flush_if_id_o, busy_o} !== 3'b011) begin
            errors++; $display("FAIL beq_flush1 got %b want 011", {redirect_valid_o, flush_if_id_o, busy_o});
        end
        tick();
        checks++;
        if (flush_if_id_o !== 1'b1) begin errors++; $display("FAIL beq_flush2 got %b want 1", flush_if_id_o); end
        tick();
        checks++;
        if ({flush_if_id_o, busy_o} !== 2'b00) begin errors++; $display("FAIL beq_idle got %b want 00", {flush_if_id_o, busy_o}); end
    endtask

    task automatic test_load_use;
        dec_valid_i = 1; dec_is_ctrl_i = 1; dec_uses_rs2_i = 1;
        dec_rs1_i = 5; dec_rs2_i = 9; ex_load_i = 1; ex_rd_i = 5; br_taken_i = 0;
        #1;
        checks++;
        if ({pipe_stall_o, bubble_id_ex_o} !== 2'b11) begin
            errors++; $display("FAIL lu_stall got %b want 11", {pipe_stall_o, bubble_id_ex_o});
        end
        tick();
        ex_load_i = 0; ex_rd_i = 0;
        drive_branch(20'h00200, 1'b1);
        #1;
        checks++;
        if ({pipe_stall_o, bubble_id_ex_o, redirect_valid_o, busy_o} !== 4'b0001) begin
            errors++; $display("FAIL lu_hazstall got %b want 0001", {pipe_stall_o, bubble_id_ex_o, redirect_valid_o, busy_o});
        end
        tick();
        clear_dec();
        #1;
        checks++;
        exp_pc = exp_q.pop_front();
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== exp_pc) begin
            errors++; $display("FAIL lu_redirect got v=%b pc=%h want v=1 pc=%h", redirect_valid_o, redirect_pc_o, exp_pc);
        end
        exp_taken++;
        tick(); tick(); tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL lu_idle got %b want 0", busy_o); end
    endtask

    task automatic test_x0_and_rs2;
        dec_valid_i = 1; dec_is_ctrl_i = 1; dec_uses_rs2_i = 1;
        dec_rs1_i = 0; dec_rs2_i = 0; ex_load_i = 1; ex_rd_i = 0;
        #1;
        checks++;
        if ({pipe_stall_o, bubble_id_ex_o} !== 2'b00) begin
            errors++; $display("FAIL x0_nostall got %b want 00", {pipe_stall_o, bubble_id_ex_o});
        end
        tick();
        exp_ctrl++;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL x0_idle got %b want 0", busy_o); end
        dec_uses_rs2_i = 0; dec_rs1_i = 2; dec_rs2_i = 7; ex_rd_i = 7;
        #1;
        checks++;
        if (pipe_stall_o !== 1'b0) begin errors++; $display("FAIL jalr_rs2_nostall got %b want 0", pipe_stall_o); end
        tick();
        exp_ctrl++;
        dec_uses_rs2_i = 1;
        #1;
        checks++;
        if ({pipe_stall_o, bubble_id_ex_o} !== 2'b11) begin
            errors++; $display("FAIL rs2_stall got %b want 11", {pipe_stall_o, bubble_id_ex_o});
        end
        clear_dec();
        #1;
    endtask

    task automatic test_backpressure;
        fetch_ready_i = 0;
        drive_branch(20'h003A0, 1'b0);
        tick();
        clear_dec();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (redirect_valid_o !== 1'b1 || redirect_pc_o !== exp_q[0]) begin
                errors++; $display("FAIL bp_hold%0d got v=%b pc=%h want v=1 pc=%h", i, redirect_valid_o, redirect_pc_o, exp_q[0]);
            end
            tick();
        end
        fetch_ready_i = 1;
        #1;
        checks++;
        exp_pc = exp_q.pop_front();
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== exp_pc) begin
            errors++; $display("FAIL bp_accept got v=%b pc=%h want v=1 pc=%h", redirect_valid_o, redirect_pc_o, exp_pc);
        end
        exp_taken++;
        tick();
        checks++;
        if ({redirect_valid_o, flush_if_id_o} !== 2'b01) begin
            errors++; $display("FAIL bp_after got %b want 01", {redirect_valid_o, flush_if_id_o});
        end
        tick(); tick();
        fetch_ready_i = 0;
        drive_branch(20'h0055C, 1'b1);
        tick();
        clear_dec();
        for (int k = 0; k < 5; k++) begin
            fetch_ready_i = k >= 3;
            stall_en_i = k >= 3;
            #1;
            checks++;
            if (redirect_valid_o !== 1'b1 || redirect_pc_o !== exp_q[0]) begin
                errors++; $display("FAIL st_hold%0d got v=%b pc=%h want v=1 pc=%h", k, redirect_valid_o, redirect_pc_o, exp_q[0]);
            end
            tick();
        end
        stall_en_i = 0;
        fetch_ready_i = 1;
        #1;
        checks++;
        exp_pc = exp_q.pop_front();
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== exp_pc) begin
            errors++; $display("FAIL st_accept got v=%b pc=%h want v=1 pc=%h", redirect_valid_o, redirect_pc_o, exp_pc);
        end
        exp_taken++;
        tick();
        checks++;
        if (redirect_valid_o !== 1'b0) begin errors++; $display("FAIL st_after got %b want 0", redirect_valid_o); end
        tick(); tick();
    endtask

    task automatic test_jalr_wdt;
        fetch_ready_i = 1;
        drive_branch(20'h00123, 1'b0);
        tick();
        clear_dec();
        #1;
        checks++;
        exp_pc = exp_q.pop_front();
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== exp_pc) begin
            errors++; $display("FAIL jalr_pc got v=%b pc=%h want v=1 pc=%h", redirect_valid_o, redirect_pc_o, exp_pc);
        end
        exp_taken++;
        tick();
        checks++;
        if (stat_ctrl_o !== (STATS ? 32'(exp_ctrl) : 32'd0) || stat_taken_o !== (STATS ? 32'(exp_taken) : 32'd0)) begin
            errors++; $display("FAIL stats got ctrl=%0d taken=%0d want ctrl=%0d taken=%0d", stat_ctrl_o, stat_taken_o,
                               STATS ? exp_ctrl : 0, STATS ? exp_taken : 0);
        end
        checks++;
        if (flush_if_id_o !== 1'b1) begin errors++; $display("FAIL wdt_preflush got %b want 1", flush_if_id_o); end
        wdt_reset_i = 1;
        tick();
        wdt_reset_i = 0;
        #1;
        checks++;
        if ({pipe_stall_o, bubble_id_ex_o, redirect_valid_o, flush_if_id_o, busy_o} !== 5'b0 || redirect_pc_o !== '0) begin
            errors++; $display("FAIL wdt_outputs got %b pc=%h want 00000 pc=0",
                               {pipe_stall_o, bubble_id_ex_o, redirect_valid_o, flush_if_id_o, busy_o}, redirect_pc_o);
        end
        checks++;
        if (stat_ctrl_o !== 0 || stat_taken_o !== 0) begin
            errors++; $display("FAIL wdt_stats got ctrl=%0d taken=%0d want 0", stat_ctrl_o, stat_taken_o);
        end
    endtask

    initial begin
        test_reset();
        test_taken_no_hazard();
        test_load_use();
        test_x0_and_rs2();
        test_backpressure();
        test_jalr_wdt();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
